// File: rtl/vram_pkg.sv
// Shared state encoding and default constants for the VRAM arbiter slice.
package vram_pkg;
   localparam int unsigned REFRESH_ROW_BITS   = 7;
   localparam int unsigned DEF_ACCESS_CYCLES  = 4;
   localparam int unsigned DEF_REFRESH_PERIOD = 912;
   localparam int unsigned DEF_AW             = 12;
   localparam int unsigned DEF_DW             = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      VID  = 2'd1,
      REF  = 2'd2,
      CPU  = 2'd3
   } state_t;
endpackage

// File: rtl/vram_refresh_timer.sv
// Free-running scanline refresh timer: raises ref_pend once per period,
// flags a lost refresh, and steps the refresh row when a refresh is taken.
module vram_refresh_timer
   import vram_pkg::*;
#(
   parameter int unsigned REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
   input  logic                        clk_14m,
   input  logic                        rst_n,
   input  logic                        ref_ack,
   output logic                        ref_pend,
   output logic                        ref_miss,
   output logic [REFRESH_ROW_BITS-1:0] ref_row
);
   localparam int unsigned TW = $clog2(REFRESH_PERIOD);
   localparam logic [TW-1:0] RELOAD = TW'(REFRESH_PERIOD - 1);

   logic [TW-1:0] timer;
   logic          tick;

   assign tick = (timer == '0);

   // The row is captured by the arbiter on the same edge ref_ack is seen,
   // so stepping it here is equivalent to stepping it on REF exit.
   always_ff @(posedge clk_14m or negedge rst_n) begin
      if (!rst_n) begin
         timer    <= RELOAD;
         ref_pend <= 1'b0;
         ref_miss <= 1'b0;
         ref_row  <= '0;
      end else begin
         timer <= tick ? RELOAD : timer - 1'b1;
         if (tick) begin
            ref_pend <= 1'b1;
            if (ref_pend && !ref_ack) ref_miss <= 1'b1;
         end else if (ref_ack) begin
            ref_pend <= 1'b0;
         end
         if (ref_ack) ref_row <= ref_row + 1'b1;
      end
   end
endmodule

// File: rtl/vram_arbiter.sv
// Fixed-priority arbiter sharing one RAM port between video fetch, refresh
// and the 8080 CPU, issuing fixed-length RAM cycles.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int unsigned ACCESS_CYCLES  = DEF_ACCESS_CYCLES,
   parameter int unsigned REFRESH_PERIOD = DEF_REFRESH_PERIOD,
   parameter int unsigned AW             = DEF_AW,
   parameter int unsigned DW             = DEF_DW
) (
   input  logic          clk_14m,
   input  logic          rst_n,
   input  logic          vid_slot,
   input  logic [AW-1:0] vid_addr,
   output logic [DW-1:0] vid_data,
   output logic          vid_valid,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ready,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic          ram_ce,
   output logic          ram_we,
   output logic          ram_rfsh,
   output logic          vid_overrun,
   output logic          ref_miss
);
   localparam int unsigned CW = $clog2(ACCESS_CYCLES);
   localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);

   state_t                      state, state_n;
   logic [CW-1:0]               cnt, cnt_n;
   logic                        slot_d1, slot_d2, vid_rise;
   logic                        vid_pend, vid_pend_n, vid_overrun_n;
   logic                        cpu_done, cpu_done_n;
   logic                        ref_pend, ref_ack, vid_ack, start, last;
   logic [REFRESH_ROW_BITS-1:0] ref_row;
   logic [AW-1:0]               ram_addr_n;
   logic [DW-1:0]               ram_wdata_n, vid_data_n, cpu_rdata_n;
   logic                        ram_ce_n, ram_we_n, ram_rfsh_n, vid_valid_n;

   vram_refresh_timer #(.REFRESH_PERIOD(REFRESH_PERIOD)) u_refresh (
      .clk_14m  (clk_14m),
      .rst_n    (rst_n),
      .ref_ack  (ref_ack),
      .ref_pend (ref_pend),
      .ref_miss (ref_miss),
      .ref_row  (ref_row)
   );

   assign vid_rise  = slot_d1 & ~slot_d2;
   assign start     = (state == IDLE) && (state_n != IDLE);
   assign last      = (state != IDLE) && (cnt == LAST_CNT);
   assign vid_ack   = start && (state_n == VID);
   assign ref_ack   = start && (state_n == REF);
   assign cpu_ready = ~cpu_req | cpu_done;

   always_ff @(posedge clk_14m or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (vid_pend)                  state_n = VID;
            else if (ref_pend)             state_n = REF;
            else if (cpu_req && !cpu_done) state_n = CPU;
         end
         default: begin
            if (cnt == LAST_CNT) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
      endcase
   end

   // Next values for every registered output and request flag.
   always_comb begin
      ram_addr_n    = ram_addr;
      ram_wdata_n   = ram_wdata;
      ram_ce_n      = (state_n != IDLE);
      ram_rfsh_n    = (state_n == REF);
      ram_we_n      = (state_n == CPU) && (start ? cpu_we : ram_we);
      vid_data_n    = vid_data;
      vid_valid_n   = last && (state == VID);
      cpu_rdata_n   = cpu_rdata;
      cpu_done_n    = cpu_req && (cpu_done || (last && (state == CPU)));
      vid_pend_n    = vid_pend;
      vid_overrun_n = vid_overrun;
      if (start) begin
         case (state_n)
            VID:     ram_addr_n = vid_addr;
            REF:     ram_addr_n = AW'(ref_row);
            CPU: begin
               ram_addr_n  = cpu_addr;
               ram_wdata_n = cpu_wdata;
            end
            default: ;
         endcase
      end
      if (last && (state == VID))            vid_data_n  = ram_rdata;
      if (last && (state == CPU) && !ram_we) cpu_rdata_n = ram_rdata;
      if (vid_rise) begin
         vid_pend_n = 1'b1;
         if (vid_pend && !vid_ack) vid_overrun_n = 1'b1;
      end else if (vid_ack) begin
         vid_pend_n = 1'b0;
      end
   end

   always_ff @(posedge clk_14m or negedge rst_n) begin
      if (!rst_n) begin
         slot_d1     <= 1'b0;
         slot_d2     <= 1'b0;
         vid_pend    <= 1'b0;
         vid_overrun <= 1'b0;
         cpu_done    <= 1'b0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         ram_ce      <= 1'b0;
         ram_we      <= 1'b0;
         ram_rfsh    <= 1'b0;
         vid_data    <= '0;
         vid_valid   <= 1'b0;
         cpu_rdata   <= '0;
      end else begin
         slot_d1     <= vid_slot;
         slot_d2     <= slot_d1;
         vid_pend    <= vid_pend_n;
         vid_overrun <= vid_overrun_n;
         cpu_done    <= cpu_done_n;
         ram_addr    <= ram_addr_n;
         ram_wdata   <= ram_wdata_n;
         ram_ce      <= ram_ce_n;
         ram_we      <= ram_we_n;
         ram_rfsh    <= ram_rfsh_n;
         vid_data    <= vid_data_n;
         vid_valid   <= vid_valid_n;
         cpu_rdata   <= cpu_rdata_n;
      end
   end
endmodule
